// File: rtl/store_queue.sv
// store_queue: ROB-ordered store queue between memory issue and the tbus arbiter.
// Define SQ_FWD_EN to add store-to-load forwarding (ld_fwd_hit / ld_fwd_data).
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif

module sq_entry_cmp (
    input  logic        vld,
    input  logic [60:0] addr,
    input  logic [63:0] mask,
    input  logic [60:0] q_addr,
    input  logic [63:0] q_mask,
`ifdef SQ_FWD_EN
    output logic        cover,
`endif
    output logic        overlap
);
    assign overlap = vld & (addr == q_addr) & (|(mask & q_mask));
`ifdef SQ_FWD_EN
    assign cover   = ((mask & q_mask) == q_mask);
`endif
endmodule

module store_queue #(
    parameter int SQ_DEPTH     = 8,
    parameter int SQ_DEPTH_LOG = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [63:0]                enq_addr,
    input  logic [63:0]                enq_data,
    input  logic [63:0]                enq_mask,
    input  logic                       enq_robidx_flag,
    input  logic [`ROB_SIZE_LOG-1:0]   enq_robidx,
    input  logic                       commit_valid,
    input  logic                       flush_valid,
    input  logic                       flush_robidx_flag,
    input  logic [`ROB_SIZE_LOG-1:0]   flush_robidx,
    output logic                       sq2arb_tbus_index_valid,
    input  logic                       sq2arb_tbus_index_ready,
    output logic [63:0]                sq2arb_tbus_index,
    output logic [63:0]                sq2arb_tbus_write_data,
    output logic [63:0]                sq2arb_tbus_write_mask,
    output logic [`TBUS_OPTYPE_RANGE]  sq2arb_tbus_operation_type,
    input  logic                       sq2arb_tbus_operation_done,
    input  logic [63:0]                ld_query_addr,
    input  logic [63:0]                ld_query_mask,
    output logic                       ld_conflict,
`ifdef SQ_FWD_EN
    output logic                       ld_fwd_hit,
    output logic [63:0]                ld_fwd_data,
`endif
    output logic                       sq_empty,
    output logic [SQ_DEPTH_LOG:0]      sq_count
);
    localparam int L = SQ_DEPTH_LOG;
    typedef logic [L:0]   ptr_t;
    typedef logic [L-1:0] idx_t;
    localparam ptr_t ONE = ptr_t'(1);

    typedef struct packed {
        logic [60:0]              addr;
        logic [63:0]              data;
        logic [63:0]              mask;
        logic                     flag;
        logic [`ROB_SIZE_LOG-1:0] robidx;
    } sq_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} drain_st_t;

    sq_entry_t           ent [SQ_DEPTH];
    ptr_t                head_q, cmt_q, tail_q, cmt_c, tail_f, spec_cnt;
    idx_t                slot, head_idx;
    drain_st_t           st_q, st_d;
    logic                pop, enq_fire, enq_keep, kill_found;
    logic [SQ_DEPTH-1:0] vld, kill, ovl;
`ifdef SQ_FWD_EN
    logic [SQ_DEPTH-1:0] cov;
`endif
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^{enq_addr[2:0], ld_query_addr[2:0]};
    assign head_idx  = head_q[L-1:0];
    assign sq_count  = tail_q - head_q;
    assign sq_empty  = (head_q == tail_q);
    assign enq_ready = (sq_count != ptr_t'(SQ_DEPTH));
    assign sq2arb_tbus_operation_type = `TBUS_WRITE;

    for (genvar i = 0; i < SQ_DEPTH; i++) begin : g_ent
        idx_t off;
        assign off     = idx_t'(i) - head_idx;
        assign vld[i]  = ({1'b0, off} < sq_count);
        assign kill[i] = flush_valid &
                         ((flush_robidx_flag ^ ent[i].flag) ^ (flush_robidx < ent[i].robidx));
        sq_entry_cmp u_cmp (
            .vld     (vld[i]),
            .addr    (ent[i].addr),
            .mask    (ent[i].mask),
            .q_addr  (ld_query_addr[63:3]),
            .q_mask  (ld_query_mask),
`ifdef SQ_FWD_EN
            .cover   (cov[i]),
`endif
            .overlap (ovl[i])
        );
    end

    // Commit first, then roll tail back to the oldest killed speculative entry.
    always_comb begin
        cmt_c = cmt_q;
        if (commit_valid && (cmt_q != tail_q))
            cmt_c = cmt_q + ONE;
        spec_cnt   = tail_q - cmt_c;
        tail_f     = tail_q;
        kill_found = 1'b0;
        slot       = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            slot = cmt_c[L-1:0] + idx_t'(k);
            if (!kill_found && (ptr_t'(k) < spec_cnt) && kill[slot]) begin
                kill_found = 1'b1;
                tail_f     = cmt_c + ptr_t'(k);
            end
        end
        enq_fire = enq_valid & enq_ready;
        enq_keep = enq_fire & ~(flush_valid &
                   ((flush_robidx_flag ^ enq_robidx_flag) ^ (flush_robidx < enq_robidx)));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= pop ? head_q + ONE : head_q;
            cmt_q  <= cmt_c;
            tail_q <= enq_keep ? tail_f + ONE : tail_f;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_keep)
            ent[tail_f[L-1:0]] <= '{addr: enq_addr[63:3], data: enq_data, mask: enq_mask,
                                   flag: enq_robidx_flag, robidx: enq_robidx};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) st_q <= S_IDLE;
        else          st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_IDLE:  if (head_q != cmt_q)               st_d = S_REQ;
            S_REQ:   if (sq2arb_tbus_index_ready)       st_d = S_WAIT;
            S_WAIT:  if (sq2arb_tbus_operation_done)    st_d = S_IDLE;
            default:                                    st_d = S_IDLE;
        endcase
    end

    // Head entry is committed, so it cannot change while REQ holds it.
    always_comb begin
        sq2arb_tbus_index_valid = 1'b0;
        sq2arb_tbus_index       = '0;
        sq2arb_tbus_write_data  = '0;
        sq2arb_tbus_write_mask  = '0;
        pop                     = 1'b0;
        case (st_q)
            S_REQ: begin
                sq2arb_tbus_index_valid = 1'b1;
                sq2arb_tbus_index       = {ent[head_idx].addr, 3'b000};
                sq2arb_tbus_write_data  = ent[head_idx].data;
                sq2arb_tbus_write_mask  = ent[head_idx].mask;
            end
            S_WAIT:  pop = sq2arb_tbus_operation_done;
            default: ;
        endcase
    end

`ifdef SQ_FWD_EN
    logic fwd_any;
    idx_t fwd_sel, fslot;
    always_comb begin
        fwd_any = 1'b0;
        fwd_sel = head_idx;
        fslot   = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            fslot = head_idx + idx_t'(k);
            if (ovl[fslot]) begin
                fwd_any = 1'b1;
                fwd_sel = fslot;
            end
        end
        ld_fwd_hit  = fwd_any & cov[fwd_sel];
        ld_conflict = fwd_any & ~cov[fwd_sel];
        ld_fwd_data = ld_fwd_hit ? (ent[fwd_sel].data & ld_query_mask) : '0;
    end
`else
    assign ld_conflict = |ovl;
`endif

`ifndef SYNTHESIS
    commit_without_spec: assert property (@(posedge clock) disable iff (!reset_n)
        !(commit_valid && (cmt_q == tail_q)))
        else $error("commit_valid with no speculative entry");
`endif
endmodule

// File: tb/tb_store_queue.sv
// Randomized bench for store_queue against a queue-based model of the store buffer.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif

module tb_store_queue;
    localparam int D  = 8;
    localparam int RL = `ROB_SIZE_LOG;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enq_valid, enq_ready, enq_robidx_flag;
    logic [63:0] enq_addr, enq_data, enq_mask;
    logic [RL-1:0] enq_robidx, flush_robidx;
    logic commit_valid, flush_valid, flush_robidx_flag;
    logic idx_valid, idx_ready, op_done;
    logic [63:0] idx, wdata, wmask;
    logic [`TBUS_OPTYPE_RANGE] optype;
    logic [63:0] ld_query_addr, ld_query_mask;
    logic ld_conflict, sq_empty;
    logic [3:0] sq_count;
`ifdef SQ_FWD_EN
    logic ld_fwd_hit;
    logic [63:0] ld_fwd_data;
`endif

    always #5 clock = ~clock;

    store_queue #(.SQ_DEPTH(D), .SQ_DEPTH_LOG(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_mask(enq_mask),
        .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
        .commit_valid(commit_valid), .flush_valid(flush_valid),
        .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
        .sq2arb_tbus_index_valid(idx_valid), .sq2arb_tbus_index_ready(idx_ready),
        .sq2arb_tbus_index(idx), .sq2arb_tbus_write_data(wdata),
        .sq2arb_tbus_write_mask(wmask), .sq2arb_tbus_operation_type(optype),
        .sq2arb_tbus_operation_done(op_done),
        .ld_query_addr(ld_query_addr), .ld_query_mask(ld_query_mask),
        .ld_conflict(ld_conflict),
`ifdef SQ_FWD_EN
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
`endif
        .sq_empty(sq_empty), .sq_count(sq_count)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mask;
        logic [RL:0] seq;
    } st_t;

    st_t         mq[$];        // oldest first; first ncmt entries are committed
    int          ncmt = 0;
    bit          outst = 0;    // arbiter holds an accepted write
    int          wcnt = 0;
    int          stall = 0;
    int          rdy_mode = 1; // 0 never ready, 1 always, 2 random
    int          done_dly = 0; // <0: random completion and spurious done pulses
    logic [RL:0] rob_next = '0;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit younger(input logic [RL:0] e, input logic [RL:0] f);
        logic [RL:0] d;
        d = e - f;
        return (d != '0) && !d[RL];
    endfunction

    function automatic logic [63:0] rand_mask();
        logic [63:0] m;
        case ($urandom_range(0, 4))
            0:       m = 64'hFF << (8 * $urandom_range(0, 7));
            1:       m = 64'hFFFF << (16 * $urandom_range(0, 3));
            2:       m = 64'hFFFF_FFFF << (32 * $urandom_range(0, 1));
            3:       m = '1;
            default: m = {$urandom, $urandom};
        endcase
        return m;
    endfunction

    function automatic logic [63:0] rand_addr();
        return 64'h8000_0000 + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
    endfunction

    task automatic idle_in();
        enq_valid = 0; enq_addr = '0; enq_data = '0; enq_mask = '0;
        enq_robidx_flag = 0; enq_robidx = '0;
        commit_valid = 0; flush_valid = 0; flush_robidx_flag = 0; flush_robidx = '0;
    endtask

    task automatic set_enq(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
        enq_valid = 1; enq_addr = a; enq_data = d; enq_mask = m;
        {enq_robidx_flag, enq_robidx} = rob_next;
    endtask

    task automatic set_flush(input logic [RL:0] s);
        flush_valid = 1;
        {flush_robidx_flag, flush_robidx} = s;
    endtask

    task automatic drive_arb();
        case (rdy_mode)
            0:       idx_ready = 0;
            1:       idx_ready = 1;
            default: idx_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (outst) op_done = (done_dly < 0) ? ($urandom_range(0, 2) == 0) : (wcnt >= done_dly);
        else       op_done = (done_dly < 0) && ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_outputs();
        bit any, cov;
        logic [63:0] fd;
        any = 0; cov = 0; fd = '0;
        chk("count", 64'(sq_count), 64'(mq.size()));
        chk("enq_ready", 64'(enq_ready), 64'(mq.size() != D));
        chk("empty", 64'(sq_empty), 64'(mq.size() == 0));
        chk("optype", 64'(optype), 64'(`TBUS_WRITE));
        foreach (mq[i])
            if (mq[i].addr[63:3] == ld_query_addr[63:3] && (mq[i].mask & ld_query_mask) != 0) begin
                any = 1;
                cov = ((ld_query_mask & ~mq[i].mask) == 0);
                fd  = mq[i].data & ld_query_mask;
            end
`ifdef SQ_FWD_EN
        chk("ld_conflict", 64'(ld_conflict), 64'(any && !cov));
        chk("ld_fwd_hit", 64'(ld_fwd_hit), 64'(any && cov));
        if (any && cov) chk("ld_fwd_data", ld_fwd_data, fd);
`else
        chk("ld_conflict", 64'(ld_conflict), 64'(any));
`endif
        if (idx_valid) begin
            chk("drain_legal", 64'(ncmt > 0 && !outst), 64'(1));
            if (mq.size() > 0) begin
                chk("drain_index", idx, {mq[0].addr[63:3], 3'b000});
                chk("drain_data", wdata, mq[0].data);
                chk("drain_mask", wmask, mq[0].mask);
            end
            stall = 0;
        end else if (ncmt > 0 && !outst) begin
            stall++;
            chk("drain_stall", 64'(stall <= 3), 64'(1));
        end else
            stall = 0;
    endtask

    // Arbiter bookkeeping, then commit, flush and enqueue in that order.
    task automatic update_model();
        bit hs, rdy0;
        logic [RL:0] fs, es;
        hs   = idx_valid && idx_ready;
        rdy0 = (mq.size() != D);
        fs   = {flush_robidx_flag, flush_robidx};
        es   = {enq_robidx_flag, enq_robidx};
        if (outst) begin
            if (op_done) begin
                void'(mq.pop_front());
                ncmt--;
                outst = 0;
            end else wcnt++;
        end
        if (hs) begin outst = 1; wcnt = 0; end
        if (commit_valid && ncmt < mq.size()) ncmt++;
        if (flush_valid)
            for (int i = mq.size() - 1; i >= ncmt; i--)
                if (younger(mq[i].seq, fs)) mq.delete(i);
        if (enq_valid && rdy0 && !(flush_valid && younger(es, fs)))
            mq.push_back('{addr: enq_addr, data: enq_data, mask: enq_mask, seq: es});
        if (flush_valid)             rob_next = fs + 1'b1;
        else if (enq_valid && rdy0)  rob_next = rob_next + 1'b1;
    endtask

    task automatic cyc();
        drive_arb();
        #1;
        check_outputs();
        update_model();
        @(negedge clock);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!idx_valid && n < 20) begin cyc(); n++; end
        chk(tag, 64'(idx_valid), 64'(1));
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        rdy_mode = 1; done_dly = 0;
        while (mq.size() != 0 && n < 300) begin
            idle_in();
            commit_valid = (ncmt < mq.size());
            cyc();
            n++;
        end
        idle_in();
        chk("drain_all_empty", 64'(sq_empty), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] dsv;
        idle_in();
        ld_query_addr = 64'h8000_0000; ld_query_mask = '1;
        idx_ready = 0; op_done = 0;
        #3;
        chk("rst_enq_ready", 64'(enq_ready), 64'(1));
        chk("rst_empty", 64'(sq_empty), 64'(1));
        chk("rst_count", 64'(sq_count), 64'(0));
        chk("rst_valid", 64'(idx_valid), 64'(0));
        chk("rst_index", idx, 64'(0));
        chk("rst_data", wdata, 64'(0));
        chk("rst_mask", wmask, 64'(0));
        chk("rst_optype", 64'(optype), 64'(`TBUS_WRITE));
        chk("rst_conflict", 64'(ld_conflict), 64'(0));
        @(negedge clock);
        reset_n = 1;

        // single store, request and completion
        rdy_mode = 1; done_dly = 1;
        set_enq(64'h8000_0010, 64'h1234_0000, 64'hFFFF_0000); cyc();
        idle_in(); commit_valid = 1; cyc();
        idle_in(); wait_valid("t1_req");
        chk("t1_index", idx, 64'h8000_0010);
        chk("t1_mask", wmask, 64'hFFFF_0000);
        chk("t1_data", wdata, 64'h1234_0000);
        n = 0;
        while (!sq_empty && n < 10) begin cyc(); n++; end
        chk("t1_empty", 64'(sq_empty), 64'(1));

        // fill, full, pop one, wrap
        rdy_mode = 0;
        for (int i = 0; i < D; i++) begin
            set_enq(rand_addr(), {$urandom, $urandom}, rand_mask()); cyc();
        end
        idle_in();
        chk("t2_full_ready", 64'(enq_ready), 64'(0));
        chk("t2_full_count", 64'(sq_count), 64'(8));
        set_enq(rand_addr(), {$urandom, $urandom}, rand_mask()); cyc();
        idle_in(); commit_valid = 1; cyc();
        idle_in(); rdy_mode = 1; done_dly = 0;
        n = 0;
        while (sq_count != 4'd7 && n < 20) begin cyc(); n++; end
        chk("t2_ready_after_pop", 64'(enq_ready), 64'(1));
        set_enq(64'h8000_0018, 64'hA5A5_0000_5A5A, '1); cyc();
        idle_in();
        chk("t2_wrap_count", 64'(sq_count), 64'(8));
        drain_all();

        // flush kills younger speculative entries
        rdy_mode = 0; rob_next = 7'(3);
        set_enq(64'h8000_0100, 64'h3, '1); cyc();
        set_enq(64'h8000_0108, 64'h4, '1); cyc();
        set_enq(64'h8000_0110, 64'h5, '1); cyc();
        idle_in(); commit_valid = 1; cyc();
        idle_in(); set_flush(7'(3)); cyc();
        idle_in();
        chk("t3_count", 64'(sq_count), 64'(1));
        wait_valid("t3_req");
        chk("t3_index", idx, 64'h8000_0100);
        drain_all();

        // commit and flush in the same cycle
        rdy_mode = 0; rob_next = 7'(4);
        set_enq(64'h8000_0200, 64'h4, '1); cyc();
        set_enq(64'h8000_0208, 64'h5, '1); cyc();
        idle_in(); commit_valid = 1; set_flush(7'(4)); cyc();
        idle_in();
        chk("t4_count", 64'(sq_count), 64'(1));
        wait_valid("t4_req");
        chk("t4_index", idx, 64'h8000_0200);

        // backpressure while requesting
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_hold_valid", 64'(idx_valid), 64'(1));
            chk("t5_hold_index", idx, 64'h8000_0200);
            chk("t5_hold_count", 64'(sq_count), 64'(1));
        end
        drain_all();

        // load query against a single store
        rdy_mode = 0;
        dsv = 64'hDEAD_BEEF_CAFE_F00D;
        set_enq(64'h8000_0000, dsv, 64'hFFFF_FFFF); cyc();
        idle_in();
        ld_query_addr = 64'h8000_0000; ld_query_mask = 64'hFF;
        #1;
`ifdef SQ_FWD_EN
        chk("t6_fwd_hit", 64'(ld_fwd_hit), 64'(1));
        chk("t6_fwd_data", ld_fwd_data, dsv & 64'hFF);
        chk("t6_conflict", 64'(ld_conflict), 64'(0));
`else
        chk("t6_conflict", 64'(ld_conflict), 64'(1));
`endif
        drain_all();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            rdy_mode = 2; done_dly = -1;
            if ($urandom_range(0, 2) != 0)
                set_enq(rand_addr(), {$urandom, $urandom}, rand_mask());
            commit_valid = (ncmt < mq.size()) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0)
                set_flush(rob_next - 7'($urandom_range(0, 10)));
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                ld_query_addr = mq[$urandom_range(0, mq.size() - 1)].addr ^ 64'($urandom_range(0, 7));
            else
                ld_query_addr = rand_addr();
            ld_query_mask = rand_mask();
            cyc();
        end
        drain_all();

        // reset while a write is outstanding
        rdy_mode = 1; done_dly = 50;
        set_enq(64'h8000_0300, 64'h77, '1); cyc();
        idle_in(); commit_valid = 1; cyc();
        idle_in();
        n = 0;
        while (!outst && n < 20) begin cyc(); n++; end
        chk("t7_outstanding", 64'(outst), 64'(1));
        reset_n = 0;
        #1;
        chk("t7_rst_valid", 64'(idx_valid), 64'(0));
        chk("t7_rst_count", 64'(sq_count), 64'(0));
        chk("t7_rst_ready", 64'(enq_ready), 64'(1));
        chk("t7_rst_empty", 64'(sq_empty), 64'(1));
        mq.delete(); ncmt = 0; outst = 0; wcnt = 0; stall = 0;
        @(negedge clock);
        reset_n = 1;
        done_dly = 0;
        for (int i = 0; i < 6; i++) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised, ROB-ordered store queue between the memory issue stage and the trinity bus arbiter.
- Issued stores enqueue speculatively and are held in program order.
- ROB commit marks the oldest speculative entry as committed.
- Committed entries drain in order to the tbus as write operations, one outstanding at a time.
- Redirect flushes remove younger speculative entries. Loads query the queue for same-doubleword hazards.

Parameters:
- SQ_DEPTH, 8, number of entries; power of two, at least 2.
- SQ_DEPTH_LOG, 3, log2(SQ_DEPTH); pointer index width. Pointers carry one extra wrap bit.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enq_valid  in  1  store enqueue request
- enq_ready  out  1  free entry available; enqueue fires on enq_valid & enq_ready
- enq_addr  in  64  store address, byte granular
- enq_data  in  64  store data, already shifted to doubleword lane
- enq_mask  in  64  bit-granular write mask, already shifted
- enq_robidx_flag  in  1  ROB wrap flag
- enq_robidx  in  `ROB_SIZE_LOG  ROB index
- commit_valid  in  1  oldest speculative store is committed this cycle
- flush_valid  in  1  redirect flush
- flush_robidx_flag  in  1  flush ROB wrap flag
- flush_robidx  in  `ROB_SIZE_LOG  flush ROB index
- sq2arb_tbus_index_valid  out  1  drain request valid
- sq2arb_tbus_index_ready  in  1  arbiter accepts request
- sq2arb_tbus_index  out  64  drain address, {addr[63:3],3'b0}
- sq2arb_tbus_write_data  out  64  drain data
- sq2arb_tbus_write_mask  out  64  drain mask
- sq2arb_tbus_operation_type  out  `TBUS_OPTYPE_RANGE  constant `TBUS_WRITE
- sq2arb_tbus_operation_done  in  1  write completed
- ld_query_addr  in  64  load address, combinational query
- ld_query_mask  in  64  load bit mask, shifted
- ld_conflict  out  1  load must replay
- sq_empty  out  1  no valid entries
- sq_count  out  SQ_DEPTH_LOG+1  valid entry count

Behaviour:
- Pointers and boundaries:
  - Three pointers with wrap bit: head (oldest), cmt (first speculative), tail (next free).
  - Invariant: head <= cmt <= tail in queue order.
  - sq_count = tail - head, using the wrap bit.
  - enq_ready = (sq_count != SQ_DEPTH). It does not anticipate a same-cycle pop.
  - Full: enq_ready=0. Empty: sq_empty=1 and the drain FSM stays in IDLE.
- Reset:
  - All pointers 0, FSM IDLE.
  - All outputs 0; enq_ready=1, sq_empty=1, operation_type=`TBUS_WRITE.
  - Reset mid-drain drops the outstanding request immediately.
- Commit:
  - commit_valid advances cmt by 1 when cmt != tail.
  - commit_valid with cmt == tail is ignored and flagged by a simulation assertion.
- Flush:
  - An entry e is killed when flush_valid & ((flush_robidx_flag ^ e.flag) ^ (flush_robidx < e.robidx)) is 1.
  - Only entries in [cmt, tail) are candidates; committed entries are never killed.
  - Entries are in age order, so tail rolls back to the oldest killed speculative entry.
- Same-cycle ordering, applied in this sequence:
  - drain pop, then commit (cmt advances past the oldest speculative entry before kill evaluation), then flush kill, then enqueue.
  - An enqueue is dropped if its own robidx satisfies the kill equation.
  - Otherwise it is written at the rolled-back tail.
- Drain FSM:
  - IDLE: if head != cmt, go to REQ.
  - REQ: index_valid=1, driving the head entry. Hold all drain outputs stable until index_ready, then go to WAIT. index_valid drops the cycle after the handshake.
  - WAIT: on operation_done, head advances by 1 and the FSM returns to IDLE. Minimum 3 cycles per store.
  - operation_done outside WAIT is ignored.
- Load query, combinational, zero latency:
  - ld_conflict = OR over valid entries of (addr[63:3] equal) & |(entry mask & ld_query_mask).
  - Both speculative and committed entries participate.

Optional Feature:
- SQ_FWD_EN, defined:
  - Adds outputs ld_fwd_hit (1) and ld_fwd_data (64).
  - Considers the youngest valid entry whose address and mask overlap the load.
  - If that entry's mask covers ld_query_mask: ld_fwd_hit=1, ld_fwd_data=entry data & ld_query_mask, and ld_conflict=0.
  - Partial cover: ld_fwd_hit=0, ld_conflict=1.
- SQ_FWD_EN undefined: the ports are absent and any overlap asserts ld_conflict.

Test Plan:
1. Enqueue addr 0x80000010, mask 0xFFFF_0000, data 0x1234_0000; commit; index_ready=1; done 2 cycles later. Required: request index=0x80000010, mask 0xFFFF_0000; head advances; sq_empty=1.
2. Enqueue 8 stores without commit. Required: enq_ready=0, sq_count=8. Commit 1 store and drain it. Required: enq_ready=1, and the next enqueue wraps tail to slot 0 with wrap bit toggled.
3. Enqueue robidx 3,4,5 (flag 0); commit 1; flush robidx 3, flag 0. Required: entries 4 and 5 killed, tail=head+1, entry 3 still drains.
4. Commit and flush robidx 4 in the same cycle with entries 4 and 5 present. Required: entry 4 committed and kept, entry 5 killed.
5. Hold index_ready=0 for 5 cycles during REQ. Required: index_valid stays 1 with stable data; no pop before operation_done.
6. Store mask 0xFFFFFFFF at 0x80000000; load query at 0x80000000 with mask 0xFF. Required: ld_conflict=1 without SQ_FWD_EN; with SQ_FWD_EN, ld_fwd_hit=1, ld_fwd_data=data & 0xFF, and ld_conflict=0.
